// File: rtl/integration3_if.sv
// Bus between integration3 and its environment: switch input, output register
// and the observation taps on the datapath and control.
interface integration3_if;
    logic [15:0] FPGAIn;
    logic [15:0] FPGAOut;
    logic [15:0] IROutBranch;
    logic [15:0] PCOutTest;
    logic [15:0] ACCTest;
    logic [15:0] SPTest;
    logic [15:0] ALUOutTest;
    logic [15:0] ALUDirectOutTest;
    logic        AluZeroTest;
    logic        ALUovflTest;
    logic [15:0] DataOut;
    logic [15:0] MemoutTest;
    logic [15:0] MeminTest;
    logic [15:0] InTest;
    logic        PCWriteTest;
    logic        IRWriteTest;
    logic        MemWriteTest;
    logic [1:0]  MemAddrTest;

    modport master (
        output FPGAIn,
        input  FPGAOut, IROutBranch, PCOutTest, ACCTest, SPTest, ALUOutTest,
               ALUDirectOutTest, AluZeroTest, ALUovflTest, DataOut, MemoutTest,
               MeminTest, InTest, PCWriteTest, IRWriteTest, MemWriteTest, MemAddrTest
    );

    modport slave (
        input  FPGAIn,
        output FPGAOut, IROutBranch, PCOutTest, ACCTest, SPTest, ALUOutTest,
               ALUDirectOutTest, AluZeroTest, ALUovflTest, DataOut, MemoutTest,
               MeminTest, InTest, PCWriteTest, IRWriteTest, MemWriteTest, MemAddrTest
    );
endinterface

// File: rtl/integration3.sv
// Multicycle 16-bit accumulator CPU: FETCH -> DECODE -> EXEC (-> WB) with a
// 1024x16 unified memory, stack pointer and one input / one output register.
module integration3 #(
    // Power-up contents of words 0..63; the rest of memory starts at zero.
    parameter logic [63:0][15:0] ProgImage = {
        {51{16'h0000}}, 16'h8001, 16'hC000, 16'h1000, 16'hC000, 16'h0010,
        {6{16'h0000}}, 16'h9008, 16'h0000
    }
) (
    input logic           CLK,
    input logic           reset,
    integration3_if.slave bus
);

    typedef enum logic [1:0] {StFetch, StDecode, StExec, StWb} stateT;
    typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluPassB} aluOpT;

    stateT       stateQ, stateD;
    logic [15:0] pcQ, pcD;
    logic [15:0] irQ, irD;
    logic [15:0] accQ, accD;
    logic [15:0] mdrQ, mdrD;
    logic [15:0] outQ, outD;
    logic [15:0] spQ, spD;
    logic [15:0] aluOutQ;
    logic [15:0] inQ;

    logic [3:0]  opcode;
    logic [15:0] sext, zext, spDec, spInc;
    logic        needWb;

    aluOpT       aluOp;
    logic [15:0] aluA, aluB, aluY;
    logic        ovfEn, aluOvfl;

    logic [1:0]  addrSel;
    logic [9:0]  memAddr;
    logic [15:0] memRdata;
    logic        pcWrite, irWrite, memWrite;

    // Not cleared by reset: contents survive an aborted program.
    logic [1023:0][15:0] mem = {{960{16'h0000}}, ProgImage};

    assign opcode = irQ[15:12];
    assign sext   = {{4{irQ[11]}}, irQ[11:0]};
    assign zext   = {4'h0, irQ[11:0]};
    assign spDec  = spQ - 16'd1;
    assign spInc  = spQ + 16'd1;
    assign needWb = (opcode >= 4'h2 && opcode <= 4'h6) || (opcode == 4'hF);

    // Control: state sequencing, ALU operand selection, address and write enables.
    always_comb begin
        stateD   = stateQ;
        aluOp    = AluAdd;
        aluA     = accQ;
        aluB     = 16'h0000;
        ovfEn    = 1'b0;
        addrSel  = 2'b00;
        pcWrite  = 1'b0;
        irWrite  = 1'b0;
        memWrite = 1'b0;
        unique case (stateQ)
            StFetch: begin
                aluA    = pcQ;
                aluB    = 16'd1;
                pcWrite = 1'b1;
                irWrite = 1'b1;
                stateD  = StDecode;
            end
            StDecode: stateD = StExec;
            StExec: begin
                stateD = needWb ? StWb : StFetch;
                case (opcode)
                    4'h0: begin aluOp = AluPassB; aluB = sext; end
                    4'h1: begin aluB = sext; ovfEn = 1'b1; end
                    4'h2: begin addrSel = 2'b01; aluB = memRdata; ovfEn = 1'b1; end
                    4'h3: begin
                        addrSel = 2'b01;
                        aluOp   = AluSub;
                        aluB    = memRdata;
                        ovfEn   = 1'b1;
                    end
                    4'h4: begin addrSel = 2'b01; aluOp = AluAnd; aluB = memRdata; end
                    4'h5: begin addrSel = 2'b01; aluOp = AluOr; aluB = memRdata; end
                    4'h6: begin addrSel = 2'b01; aluOp = AluPassB; aluB = memRdata; end
                    4'h7: begin addrSel = 2'b01; memWrite = 1'b1; end
                    4'h8: pcWrite = 1'b1;
                    4'h9: pcWrite = (accQ == 16'h0000);
                    4'hA: pcWrite = (accQ != 16'h0000);
                    4'hE: begin addrSel = 2'b11; memWrite = 1'b1; end
                    4'hF: addrSel = 2'b10;
                    default: ;
                endcase
            end
            StWb: stateD = StFetch;
            default: stateD = StFetch;
        endcase
        // Nothing may commit while reset is held, including a half-done store.
        pcWrite  = pcWrite & reset;
        irWrite  = irWrite & reset;
        memWrite = memWrite & reset;
    end

    always_comb begin
        aluY = aluB;
        unique case (aluOp)
            AluAdd:   aluY = aluA + aluB;
            AluSub:   aluY = aluA - aluB;
            AluAnd:   aluY = aluA & aluB;
            AluOr:    aluY = aluA | aluB;
            AluPassB: aluY = aluB;
            default:  aluY = aluB;
        endcase
    end

    always_comb begin
        aluOvfl = 1'b0;
        if (ovfEn) begin
            if (aluOp == AluSub) begin
                aluOvfl = (aluA[15] != aluB[15]) && (aluY[15] != aluA[15]);
            end else begin
                aluOvfl = (aluA[15] == aluB[15]) && (aluY[15] != aluA[15]);
            end
        end
    end

    always_comb begin
        unique case (addrSel)
            2'b00:   memAddr = pcQ[9:0];
            2'b01:   memAddr = zext[9:0];
            2'b10:   memAddr = spQ[9:0];
            2'b11:   memAddr = spDec[9:0];
            default: memAddr = pcQ[9:0];
        endcase
    end

    assign memRdata = mem[memAddr];

    // Datapath next-state.
    always_comb begin
        pcD  = pcQ;
        irD  = irQ;
        accD = accQ;
        mdrD = mdrQ;
        outD = outQ;
        spD  = spQ;
        unique case (stateQ)
            StFetch: begin
                pcD = aluY;
                irD = memRdata;
            end
            StExec: begin
                if (pcWrite) pcD = zext;
                case (opcode)
                    4'h0, 4'h1:                   accD = aluY;
                    4'h2, 4'h3, 4'h4, 4'h5, 4'h6: mdrD = memRdata;
                    4'hB:                         accD = inQ;
                    4'hC:                         outD = accQ;
                    4'hE:                         spD  = spDec;
                    4'hF: begin
                        mdrD = memRdata;
                        spD  = spInc;
                    end
                    default: ;
                endcase
            end
            // POP delivers the raw word; the rest take the result latched in EXEC.
            StWb: accD = (opcode == 4'hF) ? mdrQ : aluOutQ;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            stateQ  <= StFetch;
            pcQ     <= 16'h0000;
            irQ     <= 16'h0000;
            accQ    <= 16'h0000;
            mdrQ    <= 16'h0000;
            outQ    <= 16'h0000;
            spQ     <= 16'h03FF;
            aluOutQ <= 16'h0000;
            inQ     <= 16'h0000;
        end else begin
            stateQ  <= stateD;
            pcQ     <= pcD;
            irQ     <= irD;
            accQ    <= accD;
            mdrQ    <= mdrD;
            outQ    <= outD;
            spQ     <= spD;
            aluOutQ <= aluY;
            inQ     <= bus.FPGAIn;
        end
    end

    always_ff @(posedge CLK) begin
        if (memWrite) mem[memAddr] <= accQ;
    end

    assign bus.FPGAOut          = outQ;
    assign bus.IROutBranch      = irQ;
    assign bus.PCOutTest        = pcQ;
    assign bus.ACCTest          = accQ;
    assign bus.SPTest           = spQ;
    assign bus.ALUOutTest       = aluOutQ;
    assign bus.ALUDirectOutTest = aluY;
    assign bus.AluZeroTest      = (aluY == 16'h0000);
    assign bus.ALUovflTest      = aluOvfl;
    assign bus.DataOut          = memRdata;
    assign bus.MemoutTest       = mdrQ;
    assign bus.MeminTest        = accQ;
    assign bus.InTest           = inQ;
    assign bus.PCWriteTest      = pcWrite;
    assign bus.IRWriteTest      = irWrite;
    assign bus.MemWriteTest     = memWrite;
    assign bus.MemAddrTest      = addrSel;

endmodule

// File: tb/tb_integration3.sv
// Bench for integration3: built-in program vectors, hand-checked multicycle
// corners, then random input data against an instruction-level model.
module tb_integration3;

    function automatic logic [63:0][15:0] buildImg();
        logic [63:0][15:0] img;
        img = '0;
        img[0]  = 16'h07FF;  // LI 0x7FF
        img[1]  = 16'h17FF;  // ADDI 0x7FF
        img[2]  = 16'h6030;  // LW [0x30]
        img[3]  = 16'h2031;  // ADD [0x31]
        img[4]  = 16'h6032;  // LW [0x32]
        img[5]  = 16'hE000;  // PUSH
        img[6]  = 16'h0000;  // LI 0
        img[7]  = 16'hF000;  // POP
        img[8]  = 16'hB000;  // IN
        img[9]  = 16'hC000;  // OUT
        img[10] = 16'h7033;  // SW [0x33]
        img[11] = 16'h2033;  // ADD [0x33]
        img[12] = 16'h3031;  // SUB [0x31]
        img[13] = 16'h4032;  // AND [0x32]
        img[14] = 16'hE000;  // PUSH
        img[15] = 16'hB000;  // IN
        img[16] = 16'h5033;  // OR [0x33]
        img[17] = 16'hF000;  // POP
        img[18] = 16'h9015;  // BEQ 0x15
        img[19] = 16'hA016;  // BNE 0x16
        img[20] = 16'hD000;  // NOP
        img[21] = 16'hC000;  // OUT
        img[22] = 16'h1F80;  // ADDI -0x80
        img[23] = 16'hC000;  // OUT
        img[24] = 16'h8000;  // J 0
        img[48] = 16'h7FFF;
        img[49] = 16'h0001;
        img[50] = 16'h1234;
        return img;
    endfunction

    localparam logic [63:0][15:0] TestImg = buildImg();

    logic clk = 1'b0;
    logic rstA = 1'b1;
    logic rstB = 1'b1;
    int   nTests = 0;
    int   nFail = 0;

    integration3_if busA ();
    integration3_if busB ();

    integration3 dutA (.CLK(clk), .reset(rstA), .bus(busA));
    integration3 #(.ProgImage(TestImg)) dutB (.CLK(clk), .reset(rstB), .bus(busB));

    always #5 clk = ~clk;

    // Instruction-level reference state.
    logic [15:0] mMem [1024];
    logic [15:0] mPc, mAcc, mSp, mOut;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic modelStep(input logic [15:0] inVal, output int lat);
        logic [15:0] ir, sx, zx;
        ir   = mMem[mPc[9:0]];
        mPc  = mPc + 16'd1;
        sx   = {{4{ir[11]}}, ir[11:0]};
        zx   = {4'h0, ir[11:0]};
        lat  = 3;
        case (ir[15:12])
            4'h0: mAcc = sx;
            4'h1: mAcc = mAcc + sx;
            4'h2: begin mAcc = mAcc + mMem[zx[9:0]]; lat = 4; end
            4'h3: begin mAcc = mAcc - mMem[zx[9:0]]; lat = 4; end
            4'h4: begin mAcc = mAcc & mMem[zx[9:0]]; lat = 4; end
            4'h5: begin mAcc = mAcc | mMem[zx[9:0]]; lat = 4; end
            4'h6: begin mAcc = mMem[zx[9:0]]; lat = 4; end
            4'h7: mMem[zx[9:0]] = mAcc;
            4'h8: mPc = zx;
            4'h9: if (mAcc == 16'h0000) mPc = zx;
            4'hA: if (mAcc != 16'h0000) mPc = zx;
            4'hB: mAcc = inVal;
            4'hC: mOut = mAcc;
            4'hE: begin mSp = mSp - 16'd1; mMem[mSp[9:0]] = mAcc; end
            4'hF: begin mAcc = mMem[mSp[9:0]]; mSp = mSp + 16'd1; lat = 4; end
            default: ;
        endcase
    endtask

    typedef struct {
        int          edges;
        logic        rst;
        logic [15:0] pc;
        logic [15:0] acc;
        logic [15:0] sp;
        logic [15:0] out;
    } vecT;

    vecT vecs[8];

    initial begin
        logic [63:0][15:0] img;
        logic [15:0] inVal;
        int lat;

        vecs[0] = '{3, 1'b0, 16'h0000, 16'h0000, 16'h03FF, 16'h0000};
        vecs[1] = '{3, 1'b1, 16'h0001, 16'h0000, 16'h03FF, 16'h0000};
        vecs[2] = '{3, 1'b1, 16'h0008, 16'h0000, 16'h03FF, 16'h0000};
        vecs[3] = '{3, 1'b1, 16'h0009, 16'h0010, 16'h03FF, 16'h0000};
        vecs[4] = '{3, 1'b1, 16'h000A, 16'h0010, 16'h03FF, 16'h0010};
        vecs[5] = '{6, 1'b1, 16'h000C, 16'h0010, 16'h03FF, 16'h0010};
        vecs[6] = '{3, 1'b1, 16'h0001, 16'h0010, 16'h03FF, 16'h0010};
        vecs[7] = '{3, 1'b1, 16'h0002, 16'h0010, 16'h03FF, 16'h0010};

        busA.FPGAIn = 16'h5A5A;
        busB.FPGAIn = 16'hBEEF;
        #1;
        rstA = 1'b0;
        rstB = 1'b0;

        // Built-in program on dutA.
        for (int i = 0; i < 8; i++) begin
            rstA = vecs[i].rst;
            ticks(vecs[i].edges);
            check($sformatf("vec%0d PC", i), busA.PCOutTest, vecs[i].pc);
            check($sformatf("vec%0d ACC", i), busA.ACCTest, vecs[i].acc);
            check($sformatf("vec%0d SP", i), busA.SPTest, vecs[i].sp);
            check($sformatf("vec%0d FPGAOut", i), busA.FPGAOut, vecs[i].out);
        end

        // Reset state of dutB, held low all along.
        check("rst IR", busB.IROutBranch, 16'h0000);
        check("rst ALUOut", busB.ALUOutTest, 16'h0000);
        check("rst MDR", busB.MemoutTest, 16'h0000);
        check("rst InTest", busB.InTest, 16'h0000);
        check("rst PCWrite", 16'(busB.PCWriteTest), 16'h0000);
        check("rst IRWrite", 16'(busB.IRWriteTest), 16'h0000);
        check("rst MemWrite", 16'(busB.MemWriteTest), 16'h0000);

        rstB = 1'b1;
        ticks(1);
        check("fetch0 IR", busB.IROutBranch, 16'h07FF);
        check("fetch0 PC", busB.PCOutTest, 16'h0001);
        ticks(4);
        check("addi exec ALU", busB.ALUDirectOutTest, 16'h0FFE);
        check("addi exec ovfl", 16'(busB.ALUovflTest), 16'h0000);
        ticks(1);
        check("addi ACC", busB.ACCTest, 16'h0FFE);
        ticks(4);
        check("lw ACC", busB.ACCTest, 16'h7FFF);
        ticks(2);
        check("add exec ALU", busB.ALUDirectOutTest, 16'h8000);
        check("add exec ovfl", 16'(busB.ALUovflTest), 16'h0001);
        check("add exec zero", 16'(busB.AluZeroTest), 16'h0000);
        check("add exec addrsel", 16'(busB.MemAddrTest), 16'h0001);
        check("add exec DataOut", busB.DataOut, 16'h0001);
        ticks(1);
        check("add wb ACC held", busB.ACCTest, 16'h7FFF);
        check("add wb ALUOut", busB.ALUOutTest, 16'h8000);
        ticks(1);
        check("add ACC", busB.ACCTest, 16'h8000);
        ticks(4);
        check("lw2 ACC", busB.ACCTest, 16'h1234);
        ticks(2);
        check("push MemWrite", 16'(busB.MemWriteTest), 16'h0001);
        check("push addrsel", 16'(busB.MemAddrTest), 16'h0003);
        check("push Memin", busB.MeminTest, 16'h1234);
        ticks(1);
        check("push SP", busB.SPTest, 16'h03FE);
        check("push mem", dutB.mem[10'h3FE], 16'h1234);
        ticks(3);
        check("li0 ACC", busB.ACCTest, 16'h0000);
        ticks(3);
        check("pop SP", busB.SPTest, 16'h03FF);
        check("pop MDR", busB.MemoutTest, 16'h1234);
        check("pop exec ACC", busB.ACCTest, 16'h0000);
        check("pop wb IRWrite", 16'(busB.IRWriteTest), 16'h0000);
        ticks(1);
        check("pop ACC", busB.ACCTest, 16'h1234);
        check("pop next IRWrite", 16'(busB.IRWriteTest), 16'h0001);
        check("InTest", busB.InTest, 16'hBEEF);
        ticks(3);
        check("in ACC", busB.ACCTest, 16'hBEEF);
        ticks(3);
        check("out FPGAOut", busB.FPGAOut, 16'hBEEF);
        check("out PC", busB.PCOutTest, 16'h000A);
        ticks(2);
        check("sw MemWrite", 16'(busB.MemWriteTest), 16'h0001);
        #2;
        rstB = 1'b0;
        #1;
        check("sw abort MemWrite", 16'(busB.MemWriteTest), 16'h0000);
        check("sw abort PC", busB.PCOutTest, 16'h0000);
        check("sw abort ACC", busB.ACCTest, 16'h0000);
        ticks(2);
        check("sw abort mem", dutB.mem[10'h033], 16'h0000);

        // Random input data against the reference model.
        img = TestImg;
        for (int i = 0; i < 1024; i++) begin
            mMem[i] = (i < 64) ? img[i[5:0]] : 16'h0000;
        end
        mMem[10'h3FE] = 16'h1234;
        mPc  = 16'h0000;
        mAcc = 16'h0000;
        mSp  = 16'h03FF;
        mOut = 16'h0000;
        rstB = 1'b1;
        for (int n = 0; n < 200; n++) begin
            inVal       = 16'($urandom);
            busB.FPGAIn = inVal;
            modelStep(inVal, lat);
            ticks(lat);
            check($sformatf("rnd%0d PC", n), busB.PCOutTest, mPc);
            check($sformatf("rnd%0d ACC", n), busB.ACCTest, mAcc);
            check($sformatf("rnd%0d SP", n), busB.SPTest, mSp);
            check($sformatf("rnd%0d FPGAOut", n), busB.FPGAOut, mOut);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", nTests);
        $fatal(1);
    end

endmodule
